program_loader: RTL and testbench

Byte-stream writer that fills the instruction memory read by the fetch stage and then releases the pipeline. It accepts a framed byte stream (word count, instruction words, checksum) over a valid/ready handshake. It assembles big-endian 32-bit words and issues one-cycle write strobes to the instruction memory write port. After a verified load it asserts `pipe_run`; the pipeline is held idle while `pipe_run` is low.

---
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Loads the instruction memory from a framed byte stream (count, big-endian words, XOR checksum)
// and releases the pipeline once the checksum verifies.
module program_loader #(
    parameter int ADDR_WIDTH = 11,
    parameter int MAX_WORDS  = 2048
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  pipe_run,
    output logic                  error,
    output logic [11:0]           loaded_words
);

    typedef enum logic [2:0] {
        CNT_HI,
        CNT_LO,
        DATA,
        CHECK,
        RUN,
        ERROR
    } state_t;

    localparam logic [15:0] MAX_COUNT = 16'(MAX_WORDS);

    state_t                  state;
    state_t                  state_next;

    logic [7:0]              cnt_hi_q;
    logic [11:0]             count_q;
    logic [11:0]             words_rcvd;
    logic [1:0]              byte_idx;
    logic [31:0]             asm_q;
    logic [7:0]              csum_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [31:0]             wdata_q;
    logic [11:0]             loaded_q;

    logic                    accepting;
    logic                    xfer;
    logic [15:0]             count_full;
    logic                    word_done;
    logic                    last_word;

    // NOTE: in_ready decodes the state register only; reset masks it so no byte is taken during reset.
    assign accepting  = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CHECK);
    assign in_ready   = accepting && !reset;
    assign xfer       = in_valid && in_ready;

    assign count_full = {cnt_hi_q, in_byte};
    assign word_done  = xfer && (state == DATA) && (byte_idx == 2'd3);
    assign last_word  = (words_rcvd == (count_q - 12'd1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= CNT_HI;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        pipe_run   = 1'b0;
        error      = 1'b0;
        unique case (state)
            CNT_HI: begin
                if (xfer) state_next = CNT_LO;
            end
            CNT_LO: begin
                if (xfer) begin
                    if (count_full > MAX_COUNT) begin
                        state_next = ERROR;
                    end else if (count_full == 16'd0) begin
                        state_next = CHECK;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (word_done && last_word) state_next = CHECK;
            end
            CHECK: begin
                if (xfer) begin
                    state_next = (in_byte == csum_q) ? RUN : ERROR;
                end
            end
            RUN: begin
                pipe_run = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                state_next = ERROR;
            end
        endcase
    end

    // Framing datapath and write port; the instruction memory itself lives outside and is never cleared.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_hi_q   <= '0;
            count_q    <= '0;
            words_rcvd <= '0;
            byte_idx   <= '0;
            asm_q      <= '0;
            csum_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            loaded_q   <= '0;
        end else begin
            we_q <= word_done;
            if (word_done) begin
                wdata_q <= {asm_q[23:0], in_byte};
            end
            // The counters advance at the end of the strobe cycle so address and data stay stable during it.
            if (we_q) begin
                addr_q   <= addr_q + ADDR_WIDTH'(1);
                loaded_q <= loaded_q + 12'd1;
            end
            if (xfer && (state == CNT_HI)) begin
                cnt_hi_q <= in_byte;
            end
            if (xfer && (state == CNT_LO)) begin
                count_q <= count_full[11:0];
            end
            if (xfer && (state == DATA)) begin
                asm_q    <= {asm_q[23:0], in_byte};
                byte_idx <= byte_idx + 2'd1;
                csum_q   <= csum_q ^ in_byte;
                if (byte_idx == 2'd3) begin
                    words_rcvd <= words_rcvd + 12'd1;
                end
            end
        end
    end

    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign loaded_words = loaded_q;

endmodule

// File: tb/tb_program_loader.sv
// Table-driven frames plus hand-timed sequences; expected writes go through a scoreboard queue.
module tb_program_loader;

    localparam int ADDR_WIDTH = 11;
    localparam int MAX_WORDS  = 2048;

    logic                  clock;
    logic                  reset;
    logic                  in_valid;
    logic [7:0]            in_byte;
    logic                  in_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;
    logic                  pipe_run;
    logic                  error;
    logic [11:0]           loaded_words;

    program_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_byte     (in_byte),
        .in_ready    (in_ready),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .pipe_run    (pipe_run),
        .error       (error),
        .loaded_words(loaded_words)
    );

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } wr_t;

    typedef struct {
        string       name;
        logic [95:0] bytes;     // first stream byte in the top 8 bits
        int          len;
        bit          fix_sum;   // replace the last byte with the XOR of the data bytes
        int          gap_max;
        logic        exp_run;
        logic        exp_err;
        int          exp_words;
    } vec_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        sb_q[$];
    logic [7:0] frame_q[$];
    logic       prev_we = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every strobe must match the oldest expected write; strobes are single-cycle.
    always @(negedge clock) begin
        if (imem_we) begin
            check("we_single_cycle", 32'(prev_we), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_write_addr", 32'(imem_addr), 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(e.addr));
                check("write_data", imem_wdata, e.data);
            end
        end
        prev_we = imem_we;
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        #1;
        check("in_ready_during_reset", 32'(in_ready), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_pipe_run", 32'(pipe_run), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_loaded_words", 32'(loaded_words), 32'd0);
        sb_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 50) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
            in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        @(posedge clock);
        #1;
        ok = 1'b1;
    endtask

    task automatic send_frame(input int gap_max);
        int cnt = 0;
        bit ok;
        for (int i = 0; i < frame_q.size(); i++) begin
            if (gap_max > 0) begin
                int g;
                g = $urandom_range(gap_max, 0);
                in_valid = 1'b0;
                repeat (g) begin
                    @(posedge clock);
                    #1;
                end
            end
            if (i == 0) cnt = int'(frame_q[0]) << 8;
            if (i == 1) cnt = cnt | int'(frame_q[1]);
            if (i >= 5 && cnt <= MAX_WORDS && i < 2 + 4 * cnt && ((i - 2) % 4) == 3) begin
                sb_q.push_back({ADDR_WIDTH'((i - 2) / 4),
                                frame_q[i-3], frame_q[i-2], frame_q[i-1], frame_q[i]});
            end
            send_byte(frame_q[i], ok);
            if (!ok) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic load_vec(input vec_t v);
        logic [95:0] bits;
        logic [7:0]  sum;
        bits = v.bytes;
        sum  = 8'h00;
        frame_q.delete();
        for (int i = 0; i < v.len; i++) begin
            frame_q.push_back(bits[95 - 8 * i -: 8]);
        end
        if (v.fix_sum) begin
            for (int i = 2; i < v.len - 1; i++) sum = sum ^ frame_q[i];
            frame_q[v.len - 1] = sum;
        end
    endtask

    task automatic finish_frame(input string name, input logic exp_run, input logic exp_err, input int exp_words);
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check({name, "_pipe_run"}, 32'(pipe_run), 32'(exp_run));
        check({name, "_error"}, 32'(error), 32'(exp_err));
        check({name, "_loaded_words"}, 32'(loaded_words), 32'(exp_words));
        check({name, "_in_ready"}, 32'(in_ready), 32'd0);
        check({name, "_pending_writes"}, 32'(sb_q.size()), 32'd0);
    endtask

    vec_t vecs[6];
    logic [7:0] hand[11];

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        // Data XOR of the two-word frame is 0x80; fix_sum frames get it computed by the bench.
        vecs[0] = '{"two_word", 96'h000220080005AC0100008000, 11, 1'b1, 0, 1'b1, 1'b0, 2};
        vecs[1] = '{"bad_sum",  96'h000220080005AC0100008D00, 11, 1'b0, 0, 1'b0, 1'b1, 2};
        vecs[2] = '{"empty",    96'h000000000000000000000000, 3,  1'b1, 0, 1'b1, 1'b0, 0};
        vecs[3] = '{"over",     96'h080100000000000000000000, 2,  1'b0, 0, 1'b0, 1'b1, 0};
        vecs[4] = '{"gaps",     96'h000220080005AC0100008000, 11, 1'b1, 3, 1'b1, 1'b0, 2};
        vecs[5] = '{"one_word", 96'h0001DEADBEEF000000000000, 7,  1'b1, 2, 1'b1, 1'b0, 1};

        for (int v = 0; v < 6; v++) begin
            do_reset();
            load_vec(vecs[v]);
            send_frame(vecs[v].gap_max);
            finish_frame(vecs[v].name, vecs[v].exp_run, vecs[v].exp_err, vecs[v].exp_words);
        end

        // Cycle-exact two-word load, then bytes offered in RUN are ignored.
        do_reset();
        hand = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h00, 8'h80};
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_byte  = hand[i];
            if (i == 5) sb_q.push_back({ADDR_WIDTH'(0), 32'h2008_0005});
            if (i == 9) sb_q.push_back({ADDR_WIDTH'(1), 32'hAC01_0000});
            @(posedge clock);
            #1;
            if (i == 4) check("t_we_before_word", 32'(imem_we), 32'd0);
            if (i == 5) begin
                check("t_we_word0", 32'(imem_we), 32'd1);
                check("t_addr_word0", 32'(imem_addr), 32'd0);
                check("t_data_word0", imem_wdata, 32'h2008_0005);
            end
            if (i == 6) begin
                check("t_we_drop", 32'(imem_we), 32'd0);
                check("t_loaded_after_w0", 32'(loaded_words), 32'd1);
                check("t_addr_after_w0", 32'(imem_addr), 32'd1);
            end
            if (i == 9) begin
                check("t_we_word1", 32'(imem_we), 32'd1);
                check("t_run_early", 32'(pipe_run), 32'd0);
            end
        end
        check("t_pipe_run", 32'(pipe_run), 32'd1);
        check("t_loaded_final", 32'(loaded_words), 32'd2);
        check("t_we_after_sum", 32'(imem_we), 32'd0);
        in_byte = 8'hFF;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        check("t_run_ignores_ready", 32'(in_ready), 32'd0);
        check("t_run_sticky", 32'(pipe_run), 32'd1);
        check("t_run_loaded", 32'(loaded_words), 32'd2);
        in_valid = 1'b0;

        // Over-limit count: error in the cycle right after the second count byte.
        do_reset();
        in_valid = 1'b1;
        in_byte  = 8'h08;
        @(posedge clock);
        #1;
        check("o_error_early", 32'(error), 32'd0);
        check("o_ready_mid", 32'(in_ready), 32'd1);
        in_byte = 8'h01;
        @(posedge clock);
        #1;
        check("o_error", 32'(error), 32'd1);
        check("o_in_ready", 32'(in_ready), 32'd0);
        check("o_pipe_run", 32'(pipe_run), 32'd0);
        in_valid = 1'b0;
        finish_frame("o", 1'b0, 1'b1, 0);

        // Reset in the middle of word 0, then a clean one-word frame.
        do_reset();
        frame_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00};
        send_frame(0);
        do_reset();
        frame_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_frame(0);
        finish_frame("mid_reset", 1'b1, 1'b0, 1);

        // Largest accepted load: last write at address 2047, address wraps to 0 afterwards.
        do_reset();
        begin
            logic [7:0]  sum;
            logic [31:0] w;
            sum = 8'h00;
            frame_q.delete();
            frame_q.push_back(8'h08);
            frame_q.push_back(8'h00);
            for (int k = 0; k < MAX_WORDS; k++) begin
                w = 32'hA500_0000 ^ (32'(k) * 32'h0001_0203);
                for (int b = 3; b >= 0; b--) begin
                    frame_q.push_back(w[8 * b +: 8]);
                    sum = sum ^ w[8 * b +: 8];
                end
            end
            frame_q.push_back(sum);
        end
        send_frame(0);
        finish_frame("max", 1'b1, 1'b0, MAX_WORDS);
        check("max_addr_wrap", 32'(imem_addr), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
